// File: rtl/multi_cycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_controller_pkg
// Description : Shared encodings for the multi-cycle MIPS controller and its
//               datapath: FSM states, opcode/funct values, and the select
//               codes for ALUOp, MemtoReg, RegDst, ALUSrcB and PCSource.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_cycle_controller_pkg;

  // FSM state encodings; the raw value is exported on the State debug port.
  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JAL       = 4'd13,
    S_JR        = 4'd14
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ADDIU = 6'h09;
  localparam logic [5:0] c_OP_SLTI  = 6'h0a;
  localparam logic [5:0] c_OP_SLTIU = 6'h0b;
  localparam logic [5:0] c_OP_ANDI  = 6'h0c;
  localparam logic [5:0] c_OP_LUI   = 6'h0f;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2b;

  // Funct codes (instruction bits [5:0]) that need controller attention
  localparam logic [5:0] c_FN_JR    = 6'h08;
  localparam logic [5:0] c_FN_JALR  = 6'h09;

  // ALUOp codes
  localparam logic [2:0] c_ALU_ADD   = 3'd0;
  localparam logic [2:0] c_ALU_SUB   = 3'd1;
  localparam logic [2:0] c_ALU_RTYPE = 3'd2;
  localparam logic [2:0] c_ALU_AND   = 3'd3;
  localparam logic [2:0] c_ALU_SLT   = 3'd4;
  localparam logic [2:0] c_ALU_SLTU  = 3'd5;
  localparam logic [2:0] c_ALU_LUI   = 3'd6;

  // MemtoReg write-back source
  localparam logic [1:0] c_MTR_ALUOUT = 2'b00;
  localparam logic [1:0] c_MTR_MDR    = 2'b01;
  localparam logic [1:0] c_MTR_PC     = 2'b10;

  // RegDst destination select
  localparam logic [1:0] c_RDST_RT = 2'b00;
  localparam logic [1:0] c_RDST_RD = 2'b01;
  localparam logic [1:0] c_RDST_RA = 2'b10;

  // ALUSrcB operand select
  localparam logic [1:0] c_SRCB_RT      = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
  localparam logic [1:0] c_SRCB_IMM     = 2'b10;
  localparam logic [1:0] c_SRCB_IMM_SL2 = 2'b11;

  // PCSource select
  localparam logic [1:0] c_PCS_ALU    = 2'b00;
  localparam logic [1:0] c_PCS_ALUOUT = 2'b01;
  localparam logic [1:0] c_PCS_JUMP   = 2'b10;
  localparam logic [1:0] c_PCS_RS     = 2'b11;

  // R-type instructions that redirect the PC through rs (jr / jalr)
  function automatic logic is_jump_reg(input logic [5:0] funct);
    return (funct == c_FN_JR) || (funct == c_FN_JALR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_controller_if
// Description : Controller <-> datapath bundle: instruction fields in,
//               control strobes and debug state out.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_cycle_controller_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic       ExtOp;
  logic [3:0] State;

  // Controller side
  modport master (
    input  OpCode, Funct,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUOp, ExtOp, State
  );

  // Datapath side
  modport slave (
    output OpCode, Funct,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUOp, ExtOp, State
  );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_controller_alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Maps an I-type opcode to its ALU operation and immediate
//               extension mode for the EXEC_I state.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import multi_cycle_controller_pkg::*;
(
  input  wire logic [5:0] i_opcode,
  output logic      [2:0] o_alu_op,
  output logic            o_ext_op
);

  // addi/addiu fall through to ADD with sign extension; only andi zero-extends
  always_comb begin
    o_alu_op = c_ALU_ADD;
    o_ext_op = 1'b1;
    case (i_opcode)
      c_OP_ANDI: begin
        o_alu_op = c_ALU_AND;
        o_ext_op = 1'b0;
      end
      c_OP_SLTI:  o_alu_op = c_ALU_SLT;
      c_OP_SLTIU: o_alu_op = c_ALU_SLTU;
      c_OP_LUI:   o_alu_op = c_ALU_LUI;
      default:    o_alu_op = c_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_controller
// Description : Moore control FSM for a multi-cycle MIPS subset datapath.
//               Outputs decode from the state register; OpCode/Funct come
//               from the instruction register and are stable after FETCH.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                reset,
  multi_cycle_controller_if.master bus
);

  state_t     r_state;
  state_t     w_next_state;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_mem_to_reg;
  logic [1:0] w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_pc_source;
  logic [2:0] w_alu_op;
  logic       w_ext_op;

  logic [2:0] w_i_alu_op;
  logic       w_i_ext_op;

  alu_op_decode u_alu_op_decode (
    .i_opcode (bus.OpCode),
    .o_alu_op (w_i_alu_op),
    .o_ext_op (w_i_ext_op)
  );

  // State register; reset forces INIT immediately, even mid-instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection and per-state control decode; unlisted outputs stay 0
  always_comb begin
    w_next_state    = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = c_MTR_ALUOUT;
    w_reg_dst       = c_RDST_RT;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = c_SRCB_RT;
    w_pc_source     = c_PCS_ALU;
    w_alu_op        = c_ALU_ADD;
    w_ext_op        = 1'b0;

    case (r_state)
      S_INIT: begin
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        w_mem_read   = 1'b1;
        w_ir_write   = 1'b1;
        w_alu_src_b  = c_SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut
        w_alu_src_b = c_SRCB_IMM_SL2;
        w_ext_op    = 1'b1;
        case (bus.OpCode)
          c_OP_LW, c_OP_SW:  w_next_state = S_MEM_ADDR;
          c_OP_RTYPE:        w_next_state = is_jump_reg(bus.Funct) ? S_JR : S_EXEC_R;
          c_OP_ADDI, c_OP_ADDIU, c_OP_ANDI,
          c_OP_SLTI, c_OP_SLTIU, c_OP_LUI:
                             w_next_state = S_EXEC_I;
          c_OP_BEQ:          w_next_state = S_BRANCH;
          c_OP_J:            w_next_state = S_JUMP;
          c_OP_JAL:          w_next_state = S_JAL;
          default:           w_next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = c_SRCB_IMM;
        w_ext_op     = 1'b1;
        w_next_state = (bus.OpCode == c_OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        w_mem_read   = 1'b1;
        w_iord       = 1'b1;
        w_next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = c_MTR_MDR;
        w_next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_mem_write  = 1'b1;
        w_iord       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXEC_R: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = c_ALU_RTYPE;
        w_next_state = S_R_WB;
      end
      S_R_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = c_RDST_RD;
        w_next_state = S_FETCH;
      end
      S_EXEC_I: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = c_SRCB_IMM;
        w_alu_op     = w_i_alu_op;
        w_ext_op     = w_i_ext_op;
        w_next_state = S_I_WB;
      end
      S_I_WB: begin
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = c_ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = c_PCS_ALUOUT;
        w_next_state    = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = c_PCS_JUMP;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, which is the link value
        w_pc_write   = 1'b1;
        w_pc_source  = c_PCS_JUMP;
        w_reg_write  = 1'b1;
        w_reg_dst    = c_RDST_RA;
        w_mem_to_reg = c_MTR_PC;
        w_next_state = S_FETCH;
      end
      S_JR: begin
        w_pc_write   = 1'b1;
        w_pc_source  = c_PCS_RS;
        if (bus.Funct == c_FN_JALR) begin
          w_reg_write  = 1'b1;
          w_reg_dst    = c_RDST_RD;
          w_mem_to_reg = c_MTR_PC;
        end
        w_next_state = S_FETCH;
      end
      default: begin
        w_next_state = S_INIT;
      end
    endcase
  end

  assign bus.PCWrite     = w_pc_write;
  assign bus.PCWriteCond = w_pc_write_cond;
  assign bus.IorD        = w_iord;
  assign bus.MemRead     = w_mem_read;
  assign bus.MemWrite    = w_mem_write;
  assign bus.IRWrite     = w_ir_write;
  assign bus.MemtoReg    = w_mem_to_reg;
  assign bus.RegDst      = w_reg_dst;
  assign bus.RegWrite    = w_reg_write;
  assign bus.ALUSrcA     = w_alu_src_a;
  assign bus.ALUSrcB     = w_alu_src_b;
  assign bus.PCSource    = w_pc_source;
  assign bus.ALUOp       = w_alu_op;
  assign bus.ExtOp       = w_ext_op;
  assign bus.State       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_controller
// Description : Self-checking bench for multi_cycle_controller. Directed and
//               random instructions are expanded into an expected per-cycle
//               control trace from the instruction-level rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_controller;
  import multi_cycle_controller_pkg::*;

  logic clk = 1'b0;
  logic reset;

  multi_cycle_controller_if bus ();

  multi_cycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mr, mw, irw;
    logic [1:0] m2r, rdst;
    logic       rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic       ext;
  } ctl_t;

  state_t plan_q[$];

  function automatic ctl_t observe();
    ctl_t c;
    c.st   = bus.State;
    c.pcw  = bus.PCWrite;
    c.pcwc = bus.PCWriteCond;
    c.iord = bus.IorD;
    c.mr   = bus.MemRead;
    c.mw   = bus.MemWrite;
    c.irw  = bus.IRWrite;
    c.m2r  = bus.MemtoReg;
    c.rdst = bus.RegDst;
    c.rw   = bus.RegWrite;
    c.asa  = bus.ALUSrcA;
    c.asb  = bus.ALUSrcB;
    c.pcs  = bus.PCSource;
    c.aop  = bus.ALUOp;
    c.ext  = bus.ExtOp;
    return c;
  endfunction

  // Expected controls for one step of an instruction, straight from the
  // instruction-level table (numeric codes written out literally).
  function automatic ctl_t model(state_t s, logic [5:0] op, logic [5:0] fn);
    ctl_t c;
    c    = '0;
    c.st = s;
    case (s)
      S_FETCH:     begin c.mr = 1; c.irw = 1; c.asb = 2'b01; c.pcw = 1; end
      S_DECODE:    begin c.asb = 2'b11; c.ext = 1; end
      S_MEM_ADDR:  begin c.asa = 1; c.asb = 2'b10; c.ext = 1; end
      S_MEM_READ:  begin c.mr = 1; c.iord = 1; end
      S_MEM_WB:    begin c.rw = 1; c.m2r = 2'b01; end
      S_MEM_WRITE: begin c.mw = 1; c.iord = 1; end
      S_EXEC_R:    begin c.asa = 1; c.aop = 3'd2; end
      S_R_WB:      begin c.rw = 1; c.rdst = 2'b01; end
      S_EXEC_I: begin
        c.asa = 1; c.asb = 2'b10; c.ext = 1;
        if (op == 6'h0c) begin c.aop = 3'd3; c.ext = 0; end
        else if (op == 6'h0a) c.aop = 3'd4;
        else if (op == 6'h0b) c.aop = 3'd5;
        else if (op == 6'h0f) c.aop = 3'd6;
      end
      S_I_WB:      c.rw = 1;
      S_BRANCH:    begin c.asa = 1; c.aop = 3'd1; c.pcwc = 1; c.pcs = 2'b01; end
      S_JUMP:      begin c.pcw = 1; c.pcs = 2'b10; end
      S_JAL:       begin c.pcw = 1; c.pcs = 2'b10; c.rw = 1; c.rdst = 2'b10; c.m2r = 2'b10; end
      S_JR: begin
        c.pcw = 1; c.pcs = 2'b11;
        if (fn == 6'h09) begin c.rw = 1; c.rdst = 2'b01; c.m2r = 2'b10; end
      end
      default: ;
    endcase
    return c;
  endfunction

  // Instruction class -> sequence of steps (its length is the latency)
  task automatic plan(input logic [5:0] op, input logic [5:0] fn);
    plan_q = '{S_FETCH, S_DECODE};
    if (op == 6'h23) begin
      plan_q.push_back(S_MEM_ADDR); plan_q.push_back(S_MEM_READ); plan_q.push_back(S_MEM_WB);
    end else if (op == 6'h2b) begin
      plan_q.push_back(S_MEM_ADDR); plan_q.push_back(S_MEM_WRITE);
    end else if (op == 6'h00) begin
      if (fn == 6'h08 || fn == 6'h09) plan_q.push_back(S_JR);
      else begin plan_q.push_back(S_EXEC_R); plan_q.push_back(S_R_WB); end
    end else if (op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f}) begin
      plan_q.push_back(S_EXEC_I); plan_q.push_back(S_I_WB);
    end else if (op == 6'h04) plan_q.push_back(S_BRANCH);
    else if (op == 6'h02) plan_q.push_back(S_JUMP);
    else if (op == 6'h03) plan_q.push_back(S_JAL);
  endtask

  task automatic check(input string tag, input ctl_t exp);
    ctl_t got;
    got = observe();
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    n_cmp++;
    assert (!(got.mr && got.mw) && (!got.irw || got.st == 4'(S_FETCH))) else begin
      n_bad++;
      $error("FAIL %s_invariant observed mr=%b mw=%b irw=%b st=%0d expected exclusive/fetch-only",
             tag, got.mr, got.mw, got.irw, got.st);
    end
  endtask

  // Entered at a falling edge while the DUT sits in FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input string tag);
    plan(op, fn);
    bus.OpCode = op;
    bus.Funct  = fn;
    foreach (plan_q[i]) begin
      check($sformatf("%s_op%02h_fn%02h_step%0d", tag, op, fn, i), model(plan_q[i], op, fn));
      @(negedge clk);
    end
  endtask

  logic [5:0] ops [13] = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h09, 6'h0c, 6'h0a,
                           6'h0b, 6'h0f, 6'h04, 6'h02, 6'h03, 6'h3f};
  logic [5:0] fns [5]  = '{6'h08, 6'h09, 6'h26, 6'h20, 6'h2a};

  initial begin
    logic [5:0] op, fn;
    int k;
    reset      = 1'b1;
    bus.OpCode = 6'h00;
    bus.Funct  = 6'h00;

    // Reset held: INIT, all outputs low
    @(negedge clk);
    check("reset_hold", model(S_INIT, 6'h00, 6'h00));
    @(negedge clk);
    reset = 1'b0;
    #1 check("init_after_release", model(S_INIT, 6'h00, 6'h00));
    @(negedge clk);

    // Directed instructions
    run_instr(6'h23, 6'h00, "lw");
    run_instr(6'h2b, 6'h00, "sw");
    run_instr(6'h03, 6'h00, "jal");
    run_instr(6'h00, 6'h08, "jr");
    run_instr(6'h00, 6'h26, "xor");
    run_instr(6'h3f, 6'h00, "illegal");
    run_instr(6'h00, 6'h09, "jalr");
    run_instr(6'h04, 6'h00, "beq");
    run_instr(6'h02, 6'h00, "j");
    run_instr(6'h0c, 6'h00, "andi");
    run_instr(6'h0a, 6'h00, "slti");
    run_instr(6'h0b, 6'h00, "sltiu");
    run_instr(6'h0f, 6'h00, "lui");
    run_instr(6'h08, 6'h00, "addi");
    run_instr(6'h09, 6'h00, "addiu");

    // Random instruction mix, including arbitrary opcodes/functs
    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 12);
      op = ops[k];
      if (k == 12) op = 6'($urandom);
      k  = $urandom_range(0, 5);
      fn = (k == 5) ? 6'($urandom) : fns[k];
      run_instr(op, fn, "rand");
    end

    // Asynchronous reset during MEM_READ of lw
    bus.OpCode = 6'h23;
    bus.Funct  = 6'h00;
    plan(6'h23, 6'h00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lw_pre_reset_step%0d", i), model(plan_q[i], 6'h23, 6'h00));
      if (i < 3) @(negedge clk);
    end
    #2 reset = 1'b1;
    #1 check("async_reset_mid_lw", model(S_INIT, 6'h23, 6'h00));
    @(negedge clk);
    check("reset_held_mid_lw", model(S_INIT, 6'h23, 6'h00));
    reset = 1'b0;
    #1 check("init_after_mid_release", model(S_INIT, 6'h23, 6'h00));
    @(negedge clk);
    check("fetch_after_mid_release", model(S_FETCH, 6'h23, 6'h00));
    run_instr(6'h23, 6'h00, "lw_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 OpCode  input  6  instruction bits [31:26] from the instruction register.
REQ-004 Funct  input  6  instruction bits [5:0] from the instruction register.
REQ-005 PCWrite  output  1  unconditional PC load.
REQ-006 PCWriteCond  output  1  PC load when the datapath ALU zero flag is 1 (beq).
REQ-007 IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-008 MemRead  output  1  memory read enable.
REQ-009 MemWrite  output  1  memory write enable.
REQ-010 IRWrite  output  1  instruction register load.
REQ-011 MemtoReg  output  2  write-back source: 00=ALUOut, 01=MDR, 10=PC (link).
REQ-012 RegDst  output  2  destination register: 00=rt, 01=rd, 10=$31.
REQ-013 RegWrite  output  1  register file write enable.
REQ-014 ALUSrcA  output  1  ALU A operand: 0=PC, 1=rs.
REQ-015 ALUSrcB  output  2  ALU B operand: 00=rt, 01=constant 4, 10=ext imm, 11=ext imm<<2.
REQ-016 PCSource  output  2  PC source: 00=ALU result, 01=ALUOut, 10={PC[31:28],imm26,00}, 11=rs.
REQ-017 ALUOp  output  3  ALU operation: 0=ADD, 1=SUB, 2=RTYPE (decoded from Funct), 3=AND, 4=SLT, 5=SLTU, 6=LUI.
REQ-018 ExtOp  output  1  immediate extension: 1=sign, 0=zero.
REQ-019 State  output  4  current state encoding, for debug and verification.

Function
REQ-020 Moore FSM: every output SHALL be a combinational decode of the state register only; an output not listed for a state SHALL be 0.
REQ-021 INIT: all outputs SHALL be 0; next state SHALL be FETCH unconditionally.
REQ-022 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1; next state DECODE.
REQ-023 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, ExtOp=1 (computes the branch target into ALUOut); next state SHALL be selected by OpCode as follows.
REQ-024 Decode targets: 0x23/0x2b -> MEM_ADDR; 0x00 with Funct 0x08/0x09 -> JR; other 0x00 -> EXEC_R; 0x08/0x09/0x0c/0x0a/0x0b/0x0f -> EXEC_I; 0x04 -> BRANCH; 0x02 -> JUMP; 0x03 -> JAL; any other opcode -> FETCH (no-op; no write enable asserted).
REQ-025 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, ExtOp=1; next state MEM_READ for 0x23, MEM_WRITE for 0x2b.
REQ-026 MEM_READ: MemRead=1, IorD=1 -> MEM_WB. MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01 -> FETCH.
REQ-027 MEM_WRITE: MemWrite=1, IorD=1, MemRead=0 -> FETCH.
REQ-028 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE -> R_WB. R_WB: RegWrite=1, RegDst=01, MemtoReg=00 -> FETCH.
REQ-029 EXEC_I: ALUSrcA=1, ALUSrcB=10; ALUOp: ADD for 0x08/0x09, AND for 0x0c, SLT for 0x0a, SLTU for 0x0b, LUI for 0x0f; ExtOp=0 for 0x0c, otherwise 1 -> I_WB. I_WB: RegWrite=1, RegDst=00, MemtoReg=00 -> FETCH.
REQ-030 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01 -> FETCH.
REQ-031 JUMP: PCWrite=1, PCSource=10 -> FETCH.
REQ-032 JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10 -> FETCH. The link value is the already-incremented PC (PC+4).
REQ-033 JR: PCWrite=1, PCSource=11; for jalr (Funct 0x09) additionally RegWrite=1, RegDst=01, MemtoReg=10 -> FETCH.
REQ-034 Instruction latency in cycles: beq/j/jal/jr/jalr=3, R-type/I-type/sw=4, lw=5.
REQ-035 MemRead and MemWrite SHALL never both be 1; IRWrite SHALL be 1 only in FETCH.

Reset
REQ-036 While reset=1, State SHALL be INIT immediately (asynchronous, including mid-instruction) and all outputs SHALL be 0.
REQ-037 After reset deasserts, the FSM SHALL spend exactly one cycle in INIT, then enter FETCH.

Structure
REQ-038 The following SHALL live in a shared package used by the datapath: state encodings, opcode/funct constants, ALUOp/MemtoReg/RegDst/PCSource codes.
REQ-039 One sub-module, alu_op_decode, SHALL map OpCode to ALUOp and ExtOp for EXEC_I.

Verification
REQ-040 Assert reset during MEM_READ of lw -> all outputs 0 at once; after release: INIT for 1 cycle, then FETCH with MemRead=IorD(0)/IRWrite=PCWrite=1.
REQ-041 OpCode=0x23 -> FETCH,DECODE,MEM_ADDR,MEM_READ(IorD=1),MEM_WB(RegWrite=1, MemtoReg=01), 5 cycles.
REQ-042 OpCode=0x2b -> MEM_WRITE with MemWrite=1, IorD=1, MemRead=0; returns to FETCH after 4 cycles.
REQ-043 OpCode=0x03 -> JAL: PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1, 3 cycles.
REQ-044 OpCode=0x00: Funct=0x08 -> PCSource=11, RegWrite=0, 3 cycles; Funct=0x26 -> ALUOp=2, RegDst=01, 4 cycles.
REQ-045 OpCode=0x3f -> DECODE then FETCH; no RegWrite/MemWrite/PCWriteCond asserted.
